// File: rtl/tb_uart_pkg.sv
// Shared types and defaults for the UART receive monitor.
package tb_uart_pkg;

  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;
  localparam int unsigned MIN_DIV_DEFAULT    = 4;
  localparam int unsigned DIV_W              = 16;
  localparam int unsigned BYTE_W             = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  // Bit period used for a frame: requested divider, never below the floor.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] cpb,
                                                 input logic [DIV_W-1:0] floor_div);
    return (cpb < floor_div) ? floor_div : cpb;
  endfunction

endpackage

// File: rtl/tb_uart_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO only lands when a pop frees a slot.
module tb_uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tb_uart_monitor.sv
// 8N1 UART receiver feeding a byte FIFO, with sticky overflow and framing-error flags.
module tb_uart_monitor
  import tb_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned MIN_DIV    = MIN_DIV_DEFAULT
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          enable,
  input  logic [15:0]                   clks_per_bit,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          frame_err
);

  logic             rx_meta;
  logic             rxs;
  logic             rxs_d;
  state_t           state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_in;
  logic [DIV_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic             full;
  logic             empty;
  logic             stop_pt_c;
  logic             push_c;
  logic             frame_set_c;
  logic             drop_c;

  assign div_in      = clamp_div(clks_per_bit, DIV_W'(MIN_DIV));
  assign stop_pt_c   = enable && (state == ST_STOP) && (timer == '0);
  assign push_c      = stop_pt_c && rxs;
  assign frame_set_c = stop_pt_c && !rxs;
  // Full FIFO implies non-empty, so any rd_en in that cycle is a real pop.
  assign drop_c      = push_c && full && !rd_en;
  assign busy        = (state != ST_IDLE);
  assign rd_valid    = !empty;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= ST_IDLE;
      div     <= '0;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (!enable) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rxs_d && !rxs) begin
            div   <= div_in;
            timer <= (div_in >> 1) - DIV_W'(1);
            state <= ST_START;
          end
        end
        ST_START: begin
          if (timer != '0) begin
            timer <= timer - DIV_W'(1);
          end else if (!rxs) begin
            timer   <= div - DIV_W'(1);
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (timer != '0) begin
            timer <= timer - DIV_W'(1);
          end else begin
            shreg   <= {rxs, shreg[BYTE_W-1:1]};
            timer   <= div - DIV_W'(1);
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (timer != '0) begin
            timer <= timer - DIV_W'(1);
          end else begin
            state <= rxs ? ST_IDLE : ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle wins over clr_err.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (frame_set_c) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

  tb_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clock  (clock),
    .resetb (resetb),
    .push   (push_c),
    .wdata  (shreg),
    .pop    (rd_en),
    .rdata  (rd_data),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

endmodule

// File: tb/tb_tb_uart_monitor.sv
// Bench for tb_uart_monitor: directed UART frames, expected bytes queued and checked by a popping monitor.
module tb_tb_uart_monitor;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] clks_per_bit = 16'd16;
  logic        rx = 1'b1;
  logic        mon_rd = 1'b0;
  logic        tb_rd = 1'b0;
  logic        rd_en;
  logic        clr_err = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic        busy;
  logic        overflow;
  logic        frame_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  bit          auto_read = 1'b0;

  assign rd_en = mon_rd | tb_rd;

  always #5 clock = ~clock;

  tb_uart_monitor #(
    .FIFO_DEPTH (16),
    .MIN_DIV    (4)
  ) dut (
    .clock        (clock),
    .resetb       (resetb),
    .enable       (enable),
    .clks_per_bit (clks_per_bit),
    .rx           (rx),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .busy         (busy),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_valid"},  32'(rd_valid),  0);
    check({tag, "_count"},     32'(count),     0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_overflow"},  32'(overflow),  0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_rd_data"},   32'(rd_data),   0);
  endtask

  // 8N1 frame, LSB first, followed by one idle bit time.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (int'(clks_per_bit)) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (int'(clks_per_bit)) @(negedge clock);
    end
    rx = stop_bit;
    repeat (int'(clks_per_bit)) @(negedge clock);
    rx = 1'b1;
    repeat (int'(clks_per_bit)) @(negedge clock);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((count != 0 || exp_q.size() != 0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("drain_queue_left", 32'(exp_q.size()), 0);
    check("drain_count", 32'(count), 0);
  endtask

  // Monitor: pops whenever a byte is presented and compares it against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      mon_rd = 1'b0;
      if (auto_read && resetb && rd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%02h expected none", rd_data);
        end else begin
          check("rx_byte", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        mon_rd = 1'b1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check_reset_values("por");
    resetb = 1'b1;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    repeat (2) @(negedge clock);

    // Single clean byte.
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clock);
    check("a5_rd_valid", 32'(rd_valid), 1);
    check("a5_count", 32'(count), 1);
    check("a5_rd_data", 32'(rd_data), 'hA5);
    check("a5_overflow", 32'(overflow), 0);
    check("a5_frame_err", 32'(frame_err), 0);
    check("a5_busy", 32'(busy), 0);
    auto_read = 1'b1;
    wait_drain(50);

    // Short low glitch is rejected at the start-bit resample.
    clks_per_bit = 16'd100;
    rx = 1'b0;
    repeat (10) @(negedge clock);
    check("glitch_busy_mid", 32'(busy), 1);
    repeat (10) @(negedge clock);
    rx = 1'b1;
    repeat (100) @(negedge clock);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_count", 32'(count), 0);
    check("glitch_frame_err", 32'(frame_err), 0);
    clks_per_bit = 16'd16;

    // Stop bit low: framing error, byte discarded, clr_err clears it.
    send_byte(8'h3C, 1'b0);
    repeat (4) @(negedge clock);
    check("ferr_set", 32'(frame_err), 1);
    check("ferr_count", 32'(count), 0);
    check("ferr_busy", 32'(busy), 0);
    clr_err = 1'b1;
    @(negedge clock);
    clr_err = 1'b0;
    check("ferr_cleared", 32'(frame_err), 0);

    // Seventeen bytes with no reads: last one dropped.
    auto_read = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    repeat (4) @(negedge clock);
    check("ovf_count", 32'(count), 16);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_head", 32'(rd_data), 'h00);
    auto_read = 1'b1;
    wait_drain(200);
    clr_err = 1'b1;
    @(negedge clock);
    clr_err = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    // Full FIFO, pop coincides with the push of 8'hFF.
    auto_read = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send_byte(8'h20 + 8'(i), 1'b1);
    end
    repeat (4) @(negedge clock);
    check("full_count", 32'(count), 16);
    exp_q.push_back(8'hFF);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        // Stop-bit sample lands on the 155th rising edge after the start bit is driven.
        repeat (154) @(negedge clock);
        tb_rd = 1'b1;
        check("simul_head", 32'(rd_data), 'h20);
        exp_q.delete(0);
        @(negedge clock);
        tb_rd = 1'b0;
        check("simul_count_after", 32'(count), 16);
        check("simul_overflow_after", 32'(overflow), 0);
      end
    join
    check("simul_count", 32'(count), 16);
    check("simul_overflow", 32'(overflow), 0);
    auto_read = 1'b1;
    wait_drain(200);

    // Reset during data bit 4 with a byte already buffered.
    auto_read = 1'b0;
    send_byte(8'h11, 1'b1);
    repeat (4) @(negedge clock);
    check("pre_reset_count", 32'(count), 1);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);
      repeat (16) @(negedge clock);
    end
    rx = 1'b1;
    repeat (8) @(negedge clock);
    check("pre_reset_busy", 32'(busy), 1);
    resetb = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy), 0);
    check("async_reset_count", 32'(count), 0);
    repeat (2) @(negedge clock);
    check_reset_values("midrst");
    resetb = 1'b1;
    repeat (5) @(negedge clock);
    auto_read = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    wait_drain(100);
    check("post_reset_overflow", 32'(overflow), 0);
    check("post_reset_frame_err", 32'(frame_err), 0);

    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
